multicycle_control: RTL and testbench
=====================================

Name: multicycle_control

Overview:
- Main control FSM for the multicycle MIPS datapath. Sequences instruction fetch, decode, execute, memory and writeback over several clock cycles from the 6-bit opcode.
- Drives all datapath mux selects, write enables, and the 2-bit ALUOp consumed by the ALUOp-to-ALUControl decoder.
- Stalls on a memory-ready handshake. Flags unsupported opcodes.

Parameters:
OP_RTYPE, 6'b000000, R-type opcode
OP_LW, 6'b100011, load word opcode
OP_SW, 6'b101011, store word opcode
OP_BEQ, 6'b000100, branch-if-equal opcode
OP_ADDI, 6'b001000, add-immediate opcode
OP_J, 6'b000010, jump opcode

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
Op  input  6  opcode field, instr[31:26], from instruction register
mem_ready  input  1  memory access completes this cycle
IorD  output  1  memory address select: 0=PC, 1=ALUOut
MemWrite  output  1  memory write enable
IRWrite  output  1  instruction register load
RegDst  output  1  write register select: 0=rt, 1=rd
MemtoReg  output  1  writeback select: 0=ALUOut, 1=MDR
RegWrite  output  1  register file write enable
ALUSrcA  output  1  ALU A select: 0=PC, 1=register A
ALUSrcB  output  2  ALU B select: 00=B, 01=4, 10=signext imm, 11=signext imm<<2
ALUOp  output  2  00=add, 01=sub, 10=use funct
PCSrc  output  2  00=ALU result, 01=ALUOut, 10=jump target
PCWrite  output  1  unconditional PC write
Branch  output  1  conditional PC write, qualified by Zero outside this block
illegal_op  output  1  one-cycle pulse on unsupported opcode
state_o  output  4  current state encoding, for debug and bench

Behaviour:
- Moore FSM with a 4-bit state register. All outputs decode from state, except the mem_ready qualification noted below.
- Any output not listed for a state is 0.
- Reset: while rst_n=0, state=FETCH (0) asynchronously and all enables (MemWrite, IRWrite, RegWrite, PCWrite, Branch) are 0. The FETCH mux values are ALUSrcB=01, all other selects 0. illegal_op=0.
- FETCH (0):
  - IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSrc=00.
  - IRWrite=PCWrite=mem_ready.
  - mem_ready=0: hold. mem_ready=1: go to DECODE.
- DECODE (1): ALUSrcA=0, ALUSrcB=11, ALUOp=00 (branch target precompute). Next state by Op:
  - LW/SW -> MEMADR
  - RTYPE -> EXECUTE
  - BEQ -> BRANCH
  - ADDI -> ADDIEX
  - J -> JUMP
  - other -> FETCH, with illegal_op=1 for this cycle only.
- MEMADR (2): ALUSrcA=1, ALUSrcB=10, ALUOp=00. LW -> MEMRD, SW -> MEMWR.
- MEMRD (3): IorD=1. Hold until mem_ready=1, then -> MEMWB.
- MEMWB (4): RegDst=0, MemtoReg=1, RegWrite=1. -> FETCH.
- MEMWR (5): IorD=1, MemWrite=mem_ready. Hold until mem_ready=1, then -> FETCH. MemWrite is asserted for exactly one cycle.
- EXECUTE (6): ALUSrcA=1, ALUSrcB=00, ALUOp=10. -> ALUWB.
- ALUWB (7): RegDst=1, MemtoReg=0, RegWrite=1. -> FETCH.
- BRANCH (8): ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCSrc=01, Branch=1. -> FETCH.
- ADDIEX (9): ALUSrcA=1, ALUSrcB=10, ALUOp=00. -> ADDIWB.
- ADDIWB (10): RegDst=0, MemtoReg=0, RegWrite=1. -> FETCH.
- JUMP (11): PCSrc=10, PCWrite=1. -> FETCH.
- Encodings 12-15 are unreachable. If entered, go to FETCH next cycle with all enables 0.
- Latency with zero memory wait, counting from the FETCH cycle:
  - lw: 5 cycles
  - R-type, sw, addi: 4 cycles
  - beq, j: 3 cycles
  - Each mem_ready=0 cycle in FETCH, MEMRD or MEMWR adds one cycle.
- Op is sampled only in DECODE and MEMADR. It must be stable from IRWrite until FETCH is re-entered. Op changes in other states have no effect.
- Reset asserted mid-instruction: return to FETCH immediately; no write enable may glitch high.
- Enables are one-hot per cycle: at most one of RegWrite, MemWrite, PCWrite, Branch is high in any cycle. IRWrite and PCWrite are high together only in FETCH.

Test Plan:
- Reset sequence: rst_n=0 for 3 cycles, mem_ready=1 -> state_o=0 and all enables 0 throughout reset. Cycle after release: IRWrite=1, PCWrite=1, ALUSrcB=01.
- R-type: Op=000000, mem_ready=1 -> state_o sequence 0,1,6,7,0. ALUOp=10 in state 6. RegWrite=1 with RegDst=1 in state 7 only.
- lw with stall: Op=100011, mem_ready=0 for 2 cycles in MEMRD -> sequence 0,1,2,3,3,3,4,0. MemtoReg=1 and RegWrite=1 in state 4.
- sw: Op=101011 -> sequence 0,1,2,5,0. MemWrite high exactly one cycle, with IorD=1. RegWrite never asserted.
- beq then j: Op=000100 -> state 8 with ALUOp=01, Branch=1, PCSrc=01. Then Op=000010 -> state 11 with PCWrite=1, PCSrc=10.
- Illegal and abort: Op=111111 -> illegal_op pulses one cycle in DECODE, then state_o=0. Separately, drop rst_n during MEMADR -> state_o=0 immediately and no enable pulses.

Source files
------------

// File: rtl/multicycle_control.sv
// Main control FSM for the multicycle MIPS datapath: sequences fetch, decode,
// execute, memory and writeback from the opcode and stalls on mem_ready.
module multicycle_control #(
  parameter logic [5:0] OP_RTYPE = 6'b000000,
  parameter logic [5:0] OP_LW    = 6'b100011,
  parameter logic [5:0] OP_SW    = 6'b101011,
  parameter logic [5:0] OP_BEQ   = 6'b000100,
  parameter logic [5:0] OP_ADDI  = 6'b001000,
  parameter logic [5:0] OP_J     = 6'b000010
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] Op,
  input  logic       mem_ready,
  output logic       IorD,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ALUOp,
  output logic [1:0] PCSrc,
  output logic       PCWrite,
  output logic       Branch,
  output logic       illegal_op,
  output logic [3:0] state_o
);

  typedef enum logic [3:0] {
    S_FETCH   = 4'd0,
    S_DECODE  = 4'd1,
    S_MEMADR  = 4'd2,
    S_MEMRD   = 4'd3,
    S_MEMWB   = 4'd4,
    S_MEMWR   = 4'd5,
    S_EXECUTE = 4'd6,
    S_ALUWB   = 4'd7,
    S_BRANCH  = 4'd8,
    S_ADDIEX  = 4'd9,
    S_ADDIWB  = 4'd10,
    S_JUMP    = 4'd11
  } state_t;

  state_t state, state_next;

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_FETCH;
    else        state <= state_next;
  end

  assign state_o = state;

  always_comb begin
    // NOTE: every output gets a default first so no path through the case
    // leaves a variable unassigned, which would infer a latch.
    state_next = S_FETCH;
    IorD       = 1'b0;
    MemWrite   = 1'b0;
    IRWrite    = 1'b0;
    RegDst     = 1'b0;
    MemtoReg   = 1'b0;
    RegWrite   = 1'b0;
    ALUSrcA    = 1'b0;
    ALUSrcB    = 2'b01;
    ALUOp      = 2'b00;
    PCSrc      = 2'b00;
    PCWrite    = 1'b0;
    Branch     = 1'b0;
    illegal_op = 1'b0;

    case (state)
      S_FETCH: begin
        IRWrite    = mem_ready;
        PCWrite    = mem_ready;
        state_next = mem_ready ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        ALUSrcB = 2'b11;
        if (Op == OP_LW || Op == OP_SW) state_next = S_MEMADR;
        else if (Op == OP_RTYPE)        state_next = S_EXECUTE;
        else if (Op == OP_BEQ)          state_next = S_BRANCH;
        else if (Op == OP_ADDI)         state_next = S_ADDIEX;
        else if (Op == OP_J)            state_next = S_JUMP;
        else begin
          state_next = S_FETCH;
          illegal_op = 1'b1;
        end
      end
      S_MEMADR: begin
        ALUSrcA    = 1'b1;
        ALUSrcB    = 2'b10;
        state_next = (Op == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        IorD       = 1'b1;
        ALUSrcB    = 2'b00;
        state_next = mem_ready ? S_MEMWB : S_MEMRD;
      end
      S_MEMWB: begin
        ALUSrcB  = 2'b00;
        MemtoReg = 1'b1;
        RegWrite = 1'b1;
      end
      S_MEMWR: begin
        IorD       = 1'b1;
        ALUSrcB    = 2'b00;
        MemWrite   = mem_ready;
        state_next = mem_ready ? S_FETCH : S_MEMWR;
      end
      S_EXECUTE: begin
        ALUSrcA    = 1'b1;
        ALUSrcB    = 2'b00;
        ALUOp      = 2'b10;
        state_next = S_ALUWB;
      end
      S_ALUWB: begin
        ALUSrcB  = 2'b00;
        RegDst   = 1'b1;
        RegWrite = 1'b1;
      end
      S_BRANCH: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b00;
        ALUOp   = 2'b01;
        PCSrc   = 2'b01;
        Branch  = 1'b1;
      end
      S_ADDIEX: begin
        ALUSrcA    = 1'b1;
        ALUSrcB    = 2'b10;
        state_next = S_ADDIWB;
      end
      S_ADDIWB: begin
        ALUSrcB  = 2'b00;
        RegWrite = 1'b1;
      end
      S_JUMP: begin
        ALUSrcB = 2'b00;
        PCSrc   = 2'b10;
        PCWrite = 1'b1;
      end
      default: begin
        ALUSrcB = 2'b00;
      end
    endcase

    // The state register is already forced to FETCH while reset is low;
    // this keeps FETCH's mem_ready-driven enables from firing meanwhile.
    if (!rst_n) begin
      MemWrite   = 1'b0;
      IRWrite    = 1'b0;
      RegWrite   = 1'b0;
      PCWrite    = 1'b0;
      Branch     = 1'b0;
      illegal_op = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: expected state and output vector are
// queued per cycle as stimulus is driven and checked at the falling edge.
module tb_multicycle_control;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_BAD   = 6'b111111;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] Op = OP_RTYPE;
  logic       mem_ready = 1'b1;
  logic       IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA;
  logic [1:0] ALUSrcB, ALUOp, PCSrc;
  logic       PCWrite, Branch, illegal_op;
  logic [3:0] state_o;

  multicycle_control dut (
    .clk(clk), .rst_n(rst_n), .Op(Op), .mem_ready(mem_ready),
    .IorD(IorD), .MemWrite(MemWrite), .IRWrite(IRWrite), .RegDst(RegDst),
    .MemtoReg(MemtoReg), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSrc(PCSrc), .PCWrite(PCWrite),
    .Branch(Branch), .illegal_op(illegal_op), .state_o(state_o)
  );

  always #5 clk = ~clk;

  // Order: IorD MemWrite IRWrite RegDst MemtoReg RegWrite ALUSrcA
  //        ALUSrcB[2] ALUOp[2] PCSrc[2] PCWrite Branch illegal_op
  logic [16:0] obs_vec;
  assign obs_vec = {IorD, MemWrite, IRWrite, RegDst, MemtoReg, RegWrite, ALUSrcA,
                    ALUSrcB, ALUOp, PCSrc, PCWrite, Branch, illegal_op};

  typedef struct packed {
    logic [3:0]  st;
    logic [16:0] vec;
  } exp_t;

  exp_t sb[$];
  int errors = 0;
  int checks = 0;

  // Output table written out from the state descriptions.
  function automatic logic [16:0] model(input int st, input logic mr,
                                        input logic ill, input logic in_rst);
    logic iord, mw, irw, rd, m2r, rw, srca, pcw, br, il;
    logic [1:0] srcb, aop, pcs;
    iord = 0; mw = 0; irw = 0; rd = 0; m2r = 0; rw = 0; srca = 0;
    pcw = 0; br = 0; il = 0; srcb = 2'b00; aop = 2'b00; pcs = 2'b00;
    if (in_rst) srcb = 2'b01;
    else begin
      case (st)
        0:  begin srcb = 2'b01; irw = mr; pcw = mr; end
        1:  begin srcb = 2'b11; il = ill; end
        2:  begin srca = 1; srcb = 2'b10; end
        3:  iord = 1;
        4:  begin m2r = 1; rw = 1; end
        5:  begin iord = 1; mw = mr; end
        6:  begin srca = 1; aop = 2'b10; end
        7:  begin rd = 1; rw = 1; end
        8:  begin srca = 1; aop = 2'b01; pcs = 2'b01; br = 1; end
        9:  begin srca = 1; srcb = 2'b10; end
        10: rw = 1;
        11: begin pcs = 2'b10; pcw = 1; end
        default: ;
      endcase
    end
    return {iord, mw, irw, rd, m2r, rw, srca, srcb, aop, pcs, pcw, br, il};
  endfunction

  task automatic push_exp(input int st, input logic mr, input logic ill);
    exp_t e;
    e.st  = st[3:0];
    e.vec = model(st, mr, ill, !rst_n);
    sb.push_back(e);
  endtask

  task automatic compare(input string tag);
    exp_t e;
    int   n_en;
    checks++;
    assert (sb.size() > 0) else begin
      errors++;
      $error("FAIL %s scoreboard empty: observed state=%0d expected an entry", tag, state_o);
    end
    if (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      assert (state_o === e.st) else begin
        errors++;
        $error("FAIL %s state: observed=%0d expected=%0d", tag, state_o, e.st);
      end
      checks++;
      assert (obs_vec === e.vec) else begin
        errors++;
        $error("FAIL %s outputs: observed=%b expected=%b", tag, obs_vec, e.vec);
      end
    end
    n_en = int'(RegWrite) + int'(MemWrite) + int'(PCWrite) + int'(Branch);
    checks++;
    assert (n_en <= 1) else begin
      errors++;
      $error("FAIL %s enable_onehot: observed=%0d enables expected<=1", tag, n_en);
    end
  endtask

  // One clock cycle: drive inputs just after the rising edge, expect state st.
  task automatic step(input logic [5:0] op, input logic mr, input logic rst,
                      input int st, input logic ill, input string tag);
    @(posedge clk);
    #1;
    Op = op;
    mem_ready = mr;
    rst_n = rst;
    push_exp(st, mr, ill);
    @(negedge clk);
    compare(tag);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset held for three cycles with mem_ready high
    for (int i = 0; i < 3; i++) step(OP_RTYPE, 1, 0, 0, 0, "reset");
    step(OP_RTYPE, 1, 1, 0, 0, "reset_release");

    // R-type: 0,1,6,7,0
    step(OP_RTYPE, 1, 1, 1, 0, "rtype_decode");
    step(OP_RTYPE, 1, 1, 6, 0, "rtype_exec");
    step(OP_RTYPE, 1, 1, 7, 0, "rtype_wb");

    // lw with two wait cycles in MEMRD; Op change in MEMRD must be ignored
    step(OP_LW, 1, 1, 0, 0, "lw_fetch");
    step(OP_LW, 1, 1, 1, 0, "lw_decode");
    step(OP_LW, 1, 1, 2, 0, "lw_memadr");
    step(OP_RTYPE, 0, 1, 3, 0, "lw_memrd_wait1");
    step(OP_LW, 0, 1, 3, 0, "lw_memrd_wait2");
    step(OP_LW, 1, 1, 3, 0, "lw_memrd_done");
    step(OP_LW, 1, 1, 4, 0, "lw_memwb");

    // sw with one wait cycle in MEMWR
    step(OP_SW, 1, 1, 0, 0, "sw_fetch");
    step(OP_SW, 1, 1, 1, 0, "sw_decode");
    step(OP_SW, 1, 1, 2, 0, "sw_memadr");
    step(OP_SW, 0, 1, 5, 0, "sw_memwr_wait");
    step(OP_SW, 1, 1, 5, 0, "sw_memwr_done");

    // beq with one wait cycle in FETCH
    step(OP_BEQ, 0, 1, 0, 0, "beq_fetch_wait");
    step(OP_BEQ, 1, 1, 0, 0, "beq_fetch");
    step(OP_BEQ, 1, 1, 1, 0, "beq_decode");
    step(OP_BEQ, 1, 1, 8, 0, "beq_branch");

    // j
    step(OP_J, 1, 1, 0, 0, "j_fetch");
    step(OP_J, 1, 1, 1, 0, "j_decode");
    step(OP_J, 1, 1, 11, 0, "j_jump");

    // addi
    step(OP_ADDI, 1, 1, 0, 0, "addi_fetch");
    step(OP_ADDI, 1, 1, 1, 0, "addi_decode");
    step(OP_ADDI, 1, 1, 9, 0, "addi_ex");
    step(OP_ADDI, 1, 1, 10, 0, "addi_wb");

    // Illegal opcode: pulse in DECODE, then back to FETCH
    step(OP_BAD, 1, 1, 0, 0, "ill_fetch");
    step(OP_BAD, 1, 1, 1, 1, "ill_decode");
    step(OP_BAD, 0, 1, 0, 0, "ill_refetch");

    // Abort: drop reset asynchronously during MEMADR
    step(OP_LW, 1, 1, 0, 0, "abort_fetch");
    step(OP_LW, 1, 1, 1, 0, "abort_decode");
    step(OP_LW, 1, 1, 2, 0, "abort_memadr");
    #2;
    rst_n = 1'b0;
    #1;
    push_exp(0, mem_ready, 0);
    compare("abort_async");
    step(OP_LW, 1, 0, 0, 0, "abort_hold");
    step(OP_RTYPE, 1, 1, 0, 0, "abort_release");
    step(OP_RTYPE, 1, 1, 1, 0, "abort_decode2");

    checks++;
    assert (sb.size() == 0) else begin
      errors++;
      $error("FAIL scoreboard_drain: observed=%0d entries expected=0", sb.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
